// File: rtl/pe_pkg.sv
// pe_pkg: shared PE control-word fields, encodings and sequencer state type.
package pe_pkg;
    localparam int CTRL_W   = 11;
    localparam int SEL_BITS = 3;
    localparam int OPC_W    = 2;
    typedef enum logic [SEL_BITS-1:0] {
        SEL_E   = 3'd0,
        SEL_S   = 3'd1,
        SEL_W   = 3'd2,
        SEL_N   = 3'd3,
        SEL_MEM = 3'd4
    } sel_t;
    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MUL = 2'b11
    } opcode_t;
    typedef struct packed {
        sel_t    out_sel;
        sel_t    op1_sel;
        sel_t    op2_sel;
        opcode_t opcode;
    } pe_ctrl_t;
    typedef enum logic [1:0] {IDLE, RUN, FIN} seq_state_t;
endpackage

// File: rtl/pe_ctx_seq_mem.sv
// pe_ctx_mem: context register file, one write port, combinational read with write-first bypass.
module pe_ctx_mem
    import pe_pkg::*;
#(
    parameter int                  CTX_DEPTH = 16,
    parameter int                  W         = pe_pkg::CTRL_W,
    parameter logic [W-1:0]        IDLE_CTRL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(CTX_DEPTH)-1:0] waddr,
    input  logic [W-1:0]                 wdata,
    input  logic [$clog2(CTX_DEPTH)-1:0] raddr,
    output logic [W-1:0]                 rdata
);
    logic [W-1:0] mem [CTX_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CTX_DEPTH; i++) mem[i] <= IDLE_CTRL;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/pe_ctx_seq.sv
// pe_ctx_seq: replays programmed PE control words, looping a set number of passes,
// then parks ctrl on IDLE_CTRL.
module pe_ctx_seq
    import pe_pkg::*;
#(
    parameter int                  CTX_DEPTH = 16,
    parameter int                  CTRL_W    = pe_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0]   IDLE_CTRL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [$clog2(CTX_DEPTH)-1:0] cfg_addr,
    input  logic [CTRL_W-1:0]            cfg_data,
    input  logic                         start,
    input  logic                         stop,
    input  logic [$clog2(CTX_DEPTH):0]   ctx_len,
    input  logic [7:0]                   loop_cnt,
    output logic [CTRL_W-1:0]            ctrl,
    output logic                         ctrl_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);
    localparam int            AW    = $clog2(CTX_DEPTH);
    localparam logic [AW:0]   DEPTH = (AW+1)'(CTX_DEPTH);

    seq_state_t        state, state_n;
    logic [AW-1:0]     pc, pc_n;
    logic [7:0]        iter, iter_n, loops_q, loops_n;
    logic [AW:0]       len_q, len_n;
    logic              last_q, last_n;
    logic [CTRL_W-1:0] ctrl_n, rd_data;
    logic              valid_n, done_n, err_n, wrap, legal;

    pe_ctx_mem #(.CTX_DEPTH(CTX_DEPTH), .W(CTRL_W), .IDLE_CTRL(IDLE_CTRL)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_we && state == IDLE),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (state == RUN ? pc : '0),
        .rdata (rd_data)
    );

    assign wrap  = {1'b0, pc} == len_q - 1'b1;
    assign legal = ctx_len != '0 && ctx_len <= DEPTH;

    // last_q marks that the word on ctrl is the final one of the final pass
    always_comb begin
        state_n = state;
        pc_n    = pc;
        iter_n  = iter;
        len_n   = len_q;
        loops_n = loops_q;
        last_n  = last_q;
        ctrl_n  = IDLE_CTRL;
        valid_n = 1'b0;
        done_n  = 1'b0;
        err_n   = cfg_we && state != IDLE;
        case (state)
            IDLE: if (start) begin
                if (legal) begin
                    state_n = RUN;
                    len_n   = ctx_len;
                    loops_n = loop_cnt;
                    pc_n    = ctx_len == 1 ? '0 : AW'(1);
                    iter_n  = ctx_len == 1 ? 8'd1 : 8'd0;
                    last_n  = ctx_len == 1 && loop_cnt == 8'd1;
                    ctrl_n  = rd_data;
                    valid_n = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
            end
            RUN: if (stop) begin
                state_n = IDLE;
            end else if (last_q) begin
                state_n = FIN;
                done_n  = 1'b1;
            end else begin
                ctrl_n  = rd_data;
                valid_n = 1'b1;
                pc_n    = wrap ? '0 : pc + 1'b1;
                iter_n  = wrap ? iter + 8'd1 : iter;
                last_n  = wrap && loops_q != 8'd0 && iter == loops_q - 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            iter       <= '0;
            len_q      <= '0;
            loops_q    <= '0;
            last_q     <= 1'b0;
            ctrl       <= IDLE_CTRL;
            ctrl_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            iter       <= iter_n;
            len_q      <= len_n;
            loops_q    <= loops_n;
            last_q     <= last_n;
            ctrl       <= ctrl_n;
            ctrl_valid <= valid_n;
            busy       <= state_n == RUN;
            done       <= done_n;
            cfg_err    <= err_n;
        end
    end
endmodule

// File: tb/tb_pe_ctx_seq.sv
// tb_pe_ctx_seq: directed and randomized playback checks against a pass-list model of the context memory.
module tb_pe_ctx_seq;
    import pe_pkg::*;
    localparam int D  = 16;
    localparam int W  = 11;
    localparam int AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, start = 1'b0, stop = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0]  cfg_data = '0;
    logic [AW:0]   ctx_len = '0;
    logic [7:0]    loop_cnt = '0;
    logic [W-1:0]  ctrl;
    logic          ctrl_valid, busy, done, cfg_err;
    logic [W-1:0]  ctx [D];
    int            errors = 0, checks = 0;

    always #5 clk = ~clk;

    pe_ctx_seq #(.CTX_DEPTH(D), .CTRL_W(W), .IDLE_CTRL('0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .stop       (stop),
        .ctx_len    (ctx_len),
        .loop_cnt   (loop_cnt),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_ctrl"}, ctrl, 0);
        chk({tag, "_valid"}, ctrl_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
        ctx[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("wr_err", cfg_err, 0);
    endtask

    // expected stream is simply loops copies of ctx[0..len-1]
    task automatic play(input int len, input int loops, input int we_at, input bit wr0,
                        input logic [W-1:0] wr0_data, input bit fin_start);
        logic [W-1:0] exp_q[$];
        @(negedge clk);
        start = 1'b1; ctx_len = (AW+1)'(len); loop_cnt = 8'(loops);
        if (wr0) begin
            cfg_we = 1'b1; cfg_addr = '0; cfg_data = wr0_data; ctx[0] = wr0_data;
        end
        for (int p = 0; p < loops; p++)
            for (int i = 0; i < len; i++) exp_q.push_back(ctx[i]);
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        foreach (exp_q[k]) begin
            chk("run_ctrl", ctrl, exp_q[k]);
            chk("run_valid", ctrl_valid, 1);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_err", cfg_err, (we_at >= 0 && k == we_at + 1) ? 1 : 0);
            cfg_we = (k == we_at); cfg_addr = AW'(1); cfg_data = '1;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        chk("fin_done", done, 1);
        idle_chk("fin");
        start = fin_start; ctx_len = (AW+1)'(2); loop_cnt = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_err", cfg_err, 0);
        idle_chk("post");
    endtask

    initial begin
        pe_ctrl_t e;
        for (int i = 0; i < D; i++) ctx[i] = '0;
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        idle_chk("rst");
        rst_n = 1'b1;

        e = '{SEL_E, SEL_E, SEL_S, OP_ADD}; wr(0, e);
        e = '{SEL_E, SEL_S, SEL_W, OP_SUB}; wr(1, e);
        e = '{SEL_S, SEL_S, SEL_W, OP_MUL}; wr(2, e);
        chk("enc_e0", ctx[0], 11'b000_000_001_00);
        play(3, 2, -1, 1'b0, '0, 1'b1);

        wr(0, 11'h2AB);
        play(1, 4, -1, 1'b0, '0, 1'b0);

        wr(0, W'($urandom)); wr(1, W'($urandom));
        @(negedge clk);
        start = 1'b1; ctx_len = (AW+1)'(2); loop_cnt = 8'd0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            chk("fe_ctrl", ctrl, ctx[k % 2]);
            chk("fe_valid", ctrl_valid, 1);
            if (k == 99) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        chk("stop_done", done, 0);
        idle_chk("stop");
        repeat (3) begin
            @(negedge clk);
            chk("stop_nodone", done, 0);
        end

        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1'b1; ctx_len = (AW+1)'(t == 0 ? 0 : 17); loop_cnt = 8'd1;
            @(negedge clk);
            start = 1'b0;
            chk("bad_err", cfg_err, 1);
            chk("bad_busy", busy, 0);
            @(negedge clk);
            chk("bad_err_clr", cfg_err, 0);
            chk("bad_busy2", busy, 0);
        end

        for (int i = 0; i < 3; i++) wr(i, W'($urandom));
        play(3, 3, 1, 1'b0, '0, 1'b0);

        play(2, 1, -1, 1'b1, 11'h155, 1'b0);

        repeat (3) begin
            int len, loops;
            len = $urandom_range(1, D);
            loops = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) wr(i, W'($urandom));
            play(len, loops, -1, 1'b0, '0, 1'b0);
        end

        @(negedge clk);
        start = 1'b1; ctx_len = (AW+1)'(2); loop_cnt = 8'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("sl_ctrl", ctrl, ctx[1]);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("sl_done", done, 0);
        idle_chk("sl");
        @(negedge clk);
        chk("sl_done2", done, 0);

        for (int i = 0; i < 4; i++) wr(i, W'($urandom_range(1, 2047)));
        @(negedge clk);
        start = 1'b1; ctx_len = (AW+1)'(4); loop_cnt = 8'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ar_pre", ctrl, ctx[2]);
        rst_n = 1'b0;
        #1;
        chk("ar_done", done, 0);
        idle_chk("ar");
        for (int i = 0; i < D; i++) ctx[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        play(3, 1, -1, 1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
